// File: rtl/mont_precomp.sv
// mont_precomp: bit-serial setup of Montgomery constants for an odd modulus n.
//   n_inv  = (-n^-1) mod 2^mod_bit
//   r_mod  = 2^mod_bit mod n
//   r2_mod = 2^(2*mod_bit) mod n
// One shift/add/compare step per cycle; 2*mod_bit cycles per valid modulus.
module mont_precomp #(
    parameter int mod_bit = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [mod_bit-1:0] n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [mod_bit-1:0] n_inv,
    output logic [mod_bit-1:0] r_mod,
    output logic [mod_bit-1:0] r2_mod
);
    localparam int CNT_W = $clog2(2*mod_bit);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mod_bit-1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*mod_bit-1);
    localparam logic [CNT_W-1:0] CNT_INV  = CNT_W'(mod_bit);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [mod_bit-1:0] n_q;
    logic [mod_bit-1:0] acc;      // n_q*ninv_q + 1, low bits cleared as we go
    logic [mod_bit-1:0] ninv_q;
    logic [mod_bit-1:0] rmod_q;   // R mod n, parked until the final edge
    logic [mod_bit:0]   x;        // running 2^k mod n_q
    logic [CNT_W-1:0]   cnt;

    logic [mod_bit+1:0] t;
    logic [mod_bit+1:0] nq_w;
    logic [mod_bit:0]   x_nxt;
    logic               n_ok;
    logic               acc_bit;

    // Doubling-and-subtract step for the R / R^2 reductions, plus input check.
    always_comb begin
        t       = {x, 1'b0};
        nq_w    = {2'b00, n_q};
        x_nxt   = (t >= nq_w) ? (mod_bit+1)'(t - nq_w) : (mod_bit+1)'(t);
        n_ok    = n[0] && (n >= mod_bit'(3));
        acc_bit = ((acc >> cnt) & mod_bit'(1)) != '0;
    end

    // Control FSM and datapath; outputs are registered and only move at the
    // final CALC edge or on a rejected start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            n_inv  <= '0;
            r_mod  <= '0;
            r2_mod <= '0;
            n_q    <= '0;
            acc    <= '0;
            ninv_q <= '0;
            rmod_q <= '0;
            x      <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_ok) begin
                            n_q    <= n;
                            acc    <= mod_bit'(1);
                            x      <= (mod_bit+1)'(1);
                            ninv_q <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            err    <= 1'b1;
                            n_inv  <= '0;
                            r_mod  <= '0;
                            r2_mod <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                CALC: begin
                    // Hensel lifting: clear bit i of acc by adding n_q<<i.
                    if (cnt < CNT_INV && acc_bit) begin
                        acc    <= acc + (n_q << cnt);
                        ninv_q <= ninv_q | (mod_bit'(1) << cnt);
                    end
                    x <= x_nxt;
                    if (cnt == CNT_MID)
                        rmod_q <= x_nxt[mod_bit-1:0];
                    if (cnt == CNT_LAST) begin
                        r_mod  <= rmod_q;
                        r2_mod <= x_nxt[mod_bit-1:0];
                        n_inv  <= ninv_q;
                        err    <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_precomp.sv
// tb_mont_precomp: directed checks on a 5-bit instance and a random odd-modulus
// sweep on an 8-bit instance against an arithmetic reference model.
module tb_mont_precomp;
    logic       clk = 1'b0;
    logic       rst;
    logic       start5, start8;
    logic [4:0] n5;
    logic [7:0] n8;
    logic       busy5, done5, err5, busy8, done8, err8;
    logic [4:0] ninv5, rmod5, r2mod5;
    logic [7:0] ninv8, rmod8, r2mod8;

    int passed = 0;
    int fails  = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mont_precomp #(.mod_bit(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .n(n5),
        .busy(busy5), .done(done5), .err(err5),
        .n_inv(ninv5), .r_mod(rmod5), .r2_mod(r2mod5)
    );

    mont_precomp #(.mod_bit(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8),
        .busy(busy8), .done(done8), .err(err8),
        .n_inv(ninv8), .r_mod(rmod8), .r2_mod(r2mod8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: brute-force search of the inverse and plain modular powers.
    function automatic longint ref_ninv(longint nn, int mb);
        longint m = longint'(1) << mb;
        for (longint v = 0; v < m; v++)
            if (((nn * v + 1) % m) == 0) return v;
        return -1;
    endfunction

    function automatic longint ref_pow2_mod(int e, longint nn);
        return (longint'(1) << e) % nn;
    endfunction

    task automatic go5(input logic [4:0] nv);
        @(negedge clk);
        n5 = nv; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0; n5 = 5'($urandom);
    endtask

    task automatic go8(input logic [7:0] nv);
        @(negedge clk);
        n8 = nv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; n8 = 8'($urandom);
    endtask

    // Called at the negedge right after the start edge; returns latency in
    // cycles from the start edge to the done cycle (-1 on timeout).
    task automatic wait5(output int lat, output int bcnt, output int both);
        int k = 0;
        bcnt = 0; both = 0;
        while (!done5 && k < 100) begin
            if (busy5) bcnt++;
            @(negedge clk);
            k++;
        end
        if (busy5 && done5) both++;
        lat = (k >= 100) ? -1 : k + 1;
    endtask

    task automatic wait8(output int lat);
        int k = 0;
        while (!done8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        lat = (k >= 100) ? -1 : k + 1;
    endtask

    task automatic res5(input string tag, input int ni, input int rm, input int r2, input int e);
        chk({tag, ".done"},  64'(done5),  64'd1);
        chk({tag, ".err"},   64'(err5),   64'(e));
        chk({tag, ".n_inv"}, 64'(ninv5),  64'(ni));
        chk({tag, ".r_mod"}, 64'(rmod5),  64'(rm));
        chk({tag, ".r2"},    64'(r2mod5), 64'(r2));
    endtask

    initial begin
        int lat, bc, both, extra, dseen;
        logic [7:0] nr;
        rst = 1'b1; start5 = 1'b0; start8 = 1'b0; n5 = '0; n8 = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy5), 64'd0);
        chk("rst.done", 64'(done5), 64'd0);
        chk("rst.err",  64'(err5),  64'd0);
        chk("rst.out",  64'({ninv5, rmod5, r2mod5}), 64'd0);
        rst = 1'b0;

        // n=23 basic run, then stability after done
        go5(5'd23); wait5(lat, bc, both);
        chk("n23.lat", 64'(lat), 64'd11);
        chk("n23.busy_cycles", 64'(bc), 64'd10);
        chk("n23.busy_and_done", 64'(both), 64'd0);
        res5("n23", 25, 9, 12, 0);
        @(negedge clk);
        chk("n23.done_pulse", 64'(done5), 64'd0);
        chk("n23.hold", 64'({ninv5, rmod5, r2mod5}), 64'({5'd25, 5'd9, 5'd12}));
        repeat (3) @(negedge clk);
        chk("n23.hold2", 64'({ninv5, rmod5, r2mod5, err5}), 64'({5'd25, 5'd9, 5'd12, 1'b0}));

        // n=31 then back-to-back n=17
        go5(5'd31); wait5(lat, bc, both);
        chk("n31.lat", 64'(lat), 64'd11);
        res5("n31", 1, 1, 1, 0);
        go5(5'd17); wait5(lat, bc, both);
        chk("n17.lat", 64'(lat), 64'd11);
        res5("n17", 15, 15, 4, 0);

        // rejected moduli
        go5(5'd22); wait5(lat, bc, both);
        chk("n22.lat", 64'(lat), 64'd1);
        chk("n22.busy", 64'(bc + int'(busy5)), 64'd0);
        res5("n22", 0, 0, 0, 1);
        @(negedge clk);
        chk("n22.err_hold", 64'(err5), 64'd1);
        go5(5'd1); wait5(lat, bc, both);
        chk("n1.lat", 64'(lat), 64'd1);
        chk("n1.busy", 64'(bc + int'(busy5)), 64'd0);
        res5("n1", 0, 0, 0, 1);
        go5(5'd17); wait5(lat, bc, both);
        chk("clr.lat", 64'(lat), 64'd11);
        res5("clr", 15, 15, 4, 0);

        // start and n toggling during CALC must be ignored
        go5(5'd23);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            n5 = 5'($urandom_range(1, 15) * 2 + 1);
            start5 = 1'b1;
            @(negedge clk);
            start5 = 1'b0;
            extra++;
            chk("ign.out_steady", 64'({ninv5, rmod5, r2mod5}), 64'({5'd15, 5'd15, 5'd4}));
        end
        wait5(lat, bc, both);
        chk("ign.lat", 64'(lat + extra), 64'd11);
        res5("ign", 25, 9, 12, 0);

        // reset on the 4th CALC cycle
        go5(5'd17);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst.busy", 64'(busy5), 64'd0);
        chk("mid_rst.done", 64'(done5), 64'd0);
        chk("mid_rst.out",  64'({ninv5, rmod5, r2mod5, err5}), 64'd0);
        dseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done5 || busy5) dseen++;
        end
        chk("mid_rst.no_done", 64'(dseen), 64'd0);
        go5(5'd17); wait5(lat, bc, both);
        chk("post_rst.lat", 64'(lat), 64'd11);
        res5("post_rst", 15, 15, 4, 0);

        // mod_bit=8 random odd sweep
        for (int i = 0; i < 200; i++) begin
            nr = 8'($urandom_range(1, 127) * 2 + 1);
            go8(nr); wait8(lat);
            chk("m8.lat", 64'(lat), 64'd17);
            chk("m8.err", 64'(err8), 64'd0);
            chk("m8.inv_prop", 64'((longint'(nr) * longint'(ninv8) + 1) % 256), 64'd0);
            chk("m8.n_inv", 64'(ninv8), 64'(ref_ninv(longint'(nr), 8)));
            chk("m8.r_mod", 64'(rmod8), 64'(ref_pow2_mod(8, longint'(nr))));
            chk("m8.r2",    64'(r2mod8), 64'(ref_pow2_mod(16, longint'(nr))));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mont_precomp.md
Name: mont_precomp

Overview:
- Upstream setup stage for the Montgomery exponentiator. It computes the per-modulus constants from an odd modulus n:
  - n_inv = (-n^-1) mod 2^mod_bit
  - r_mod = R mod n
  - r2_mod = R^2 mod n, where R = 2^mod_bit
- n_inv drives the exponentiator's n_inv input directly. r_mod and r2_mod let a later revision drop its divider-based Montgomery conversion.
- The block is fully bit-serial: one shift/add/compare step per cycle, so there are no wide dividers.

Parameters:
- mod_bit, 5: width of the modulus and of all results. R = 2^mod_bit.

Ports:
- clk, input, 1: clock. All logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a computation. Sampled only in IDLE.
- n, input, mod_bit: modulus. Latched on start acceptance, ignored at all other times.
- busy, output, 1: high while in CALC.
- done, output, 1: one-cycle pulse when results (or err) become valid.
- err, output, 1: n was rejected (even, or n < 3). Valid with done, held until the next accepted start.
- n_inv, output, mod_bit: (-n^-1) mod 2^mod_bit.
- r_mod, output, mod_bit: 2^mod_bit mod n.
- r2_mod, output, mod_bit: 2^(2*mod_bit) mod n.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, err=0; n_inv=0, r_mod=0, r2_mod=0; internal registers cleared. Reset mid-CALC aborts with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with n odd and n >= 3: latch n into n_q; acc=1 (mod_bit bits); x=1 (mod_bit+1 bits); ninv_q=0; cnt=0; go to CALC.
  - start=1 with invalid n: go to DONE with err_next=1; result registers forced to 0.
  - start=0: stay in IDLE.
- CALC, one step per cycle, cnt = 0 .. 2*mod_bit-1:
  - Inverse step, only while cnt < mod_bit (i = cnt):
    - if acc[i]=1: acc <= (acc + (n_q << i)) mod 2^mod_bit and ninv_q[i] <= 1.
    - Invariant: n_q*ninv_q + 1 ≡ 0 mod 2^(i+1).
  - Reduction step, every CALC cycle:
    - t = 2*x; x <= (t >= n_q) ? t - n_q : t.
    - x stays in [0, n_q-1], so mod_bit+1 bits suffice.
  - When cnt = mod_bit-1: capture r_mod <= next x (= R mod n).
  - When cnt = 2*mod_bit-1: capture r2_mod <= next x, n_inv <= final ninv_q, err <= 0; go to DONE. Otherwise cnt <= cnt+1.
- DONE: done=1 for exactly this one cycle, then return to IDLE.
  - Outputs n_inv, r_mod, r2_mod and err hold their values until the next accepted start.
  - They change only at the final CALC edge, or at the DONE entry on rejection.
- Latency:
  - Valid n: done is high in the cycle after 2*mod_bit CALC edges, i.e. 2*mod_bit+1 cycles after the start edge.
  - Rejected n: done is high in the cycle immediately after the start edge.
- start while busy or in DONE is ignored and not queued.
- busy = (state==CALC). done and busy are never high together.
- The cnt register is $clog2(2*mod_bit) bits wide. It never wraps inside CALC.
- rst and start together: reset wins.

Test Plan:
- mod_bit=5, n=23, start pulse -> busy high for 10 cycles, then done=1 for 1 cycle with n_inv=25, r_mod=9, r2_mod=12, err=0; outputs stable afterwards.
- n=31 -> n_inv=1, r_mod=1, r2_mod=1; then n=17 back-to-back (start on the cycle after done) -> n_inv=15, r_mod=15, r2_mod=4.
- n=22 (even) and n=1 -> done one cycle after start, err=1, n_inv=r_mod=r2_mod=0, busy never high; a following valid start clears err.
- Toggle n and pulse start during CALC for n=23 -> ignored; results still 25/9/12 at the original done time.
- Assert rst on the 4th CALC cycle -> next cycle all outputs 0, state IDLE, no done. A fresh start then completes with correct values.
- mod_bit=8 random odd n sweep (≥200 values):
  - (n*n_inv+1) mod 256 == 0
  - r_mod == 256 mod n
  - r2_mod == 65536 mod n
  - done latency == 17 cycles
